core_lsu_ctrl: RTL
==================

Name: core_lsu_ctrl

Overview:
- Parametrised load/store control unit for the EX/MEM boundary of the pipelined core.
- Computes the effective address and checks alignment.
- Generates byte strobes for XLEN = 32 or 64, and lane-shifts store data.
- Runs a single-outstanding REQ/ACK handshake to data memory, then extracts and sign- or zero-extends load data, raising one-cycle completion pulses for writeback.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- SB_W, XLEN/8: strobe width (derived, not overridable).
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  clock, rising edge.
- NRST  in  1  asynchronous active-low reset.
- ISSUE  in  1  EX stage presents a memory instruction this cycle.
- ISLOAD  in  1  instruction is a load.
- ISSTORE  in  1  instruction is a store.
- FUNCT3  in  3  access size and signedness.
- BASE  in  XLEN  rs1 value.
- IMM  in  XLEN  sign-extended offset.
- WDATA  in  XLEN  rs2 value for stores.
- BUSY  out  1  unit not idle; upstream holds ISSUE and operands.
- DMEM_REQ  out  1  memory request.
- DMEM_WE  out  1  write enable; 1 = store.
- DMEM_ADDR  out  XLEN  XLEN-aligned address (low log2(SB_W) bits zero).
- DMEM_STRB  out  SB_W  byte lane enables.
- DMEM_WDATA  out  XLEN  lane-shifted store data.
- DMEM_ACK  in  1  memory accepted/completed the request.
- DMEM_RDATA  in  XLEN  read data, valid with ACK.
- LOAD_DATA  out  XLEN  extended load result.
- LOAD_VALID  out  1  one-cycle pulse: LOAD_DATA valid.
- STORE_DONE  out  1  one-cycle pulse: store completed.
- EXC_MISALIGN  out  1  one-cycle pulse: misaligned or illegal access; no request issued.
- EXC_ADDR  out  XLEN  faulting effective address.

Behaviour:
- Reset: asynchronous on NRST low; every output is 0 and FSM = IDLE. Reset mid-transaction drops DMEM_REQ immediately; the pending access is abandoned and no pulse is produced.
- Effective address: ea = BASE + IMM, modulo 2^XLEN. off = ea[log2(SB_W)-1:0].
- FUNCT3 decode: 000 = B, 001 = H, 010 = W, 011 = D, 100 = BU, 101 = HU, 110 = WU.
  - D and WU are legal only when XLEN = 64; 111 and out-of-width codes are illegal.
  - Stores use sizes B/H/W/D only; store FUNCT3 of 1xx is illegal.
- Alignment: H requires ea[0] = 0; W requires ea[1:0] = 0; D requires ea[2:0] = 0.
- Strobe: the size mask (1, 3, 0xF or 0xFF) shifted left by off.
- DMEM_WDATA: WDATA shifted left by 8*off.
- ISLOAD and ISSTORE both high: the load takes priority.
- FSM states:
  - IDLE: BUSY = 0. On ISSUE with (ISLOAD|ISSTORE):
    - If illegal or misaligned: pulse EXC_MISALIGN next cycle, load EXC_ADDR = ea, stay IDLE.
    - Otherwise: register address, strobe, write data and size, then go to REQ.
    - ISSUE with neither ISLOAD nor ISSTORE is ignored.
  - REQ: DMEM_REQ = 1. Address, strobe, write data and WE are stable until ACK. On DMEM_ACK, capture DMEM_RDATA and go to RESP.
  - RESP: pulse LOAD_VALID or STORE_DONE for one cycle, then return to IDLE.
- BUSY = (state != IDLE). ISSUE while BUSY is ignored.
- Minimum latency: ISSUE at edge N, DMEM_REQ high in cycle N+1; ACK at edge N+1 gives the pulse in cycle N+2.
- ACK in IDLE or RESP is ignored.
- Load extraction: shift the captured data right by 8*off, then sign-extend (B/H/W) or zero-extend (BU/HU/WU/D) from the access size.
- LOAD_DATA holds its value until the next load completes.

Optional Feature:
- Macro: CORE_LSU_TIMEOUT_EN.
- With the macro defined:
  - An 8..16-bit counter runs in REQ and clears on entry.
  - If the count reaches TIMEOUT_CYCLES without ACK: drop DMEM_REQ, pulse output EXC_BUSERR (extra port, 1 bit) with EXC_ADDR = ea, return to IDLE; no LOAD_VALID or STORE_DONE.
- Without the macro: no counter, no EXC_BUSERR port, and REQ waits indefinitely.

Decomposition:
- Shared package/header (define.vh): FUNCT3 size encodings, state encodings, size masks.
- Natural sub-module: core_lsu_align. Purely combinational; takes ea, FUNCT3, ISSTORE and WDATA; produces strobe, shifted write data and the misalign/illegal flag.
- core_lsu_ctrl holds the FSM, registers and load extraction.

Test Plan:
- XLEN = 32, LB, BASE = 0x1000, IMM = 3, ACK one cycle after REQ, RDATA = 0x80_00_00_00 -> DMEM_ADDR = 0x1000, STRB = 1000, LOAD_DATA = 0xFFFFFF80, LOAD_VALID one pulse.
- XLEN = 32, SH, ea = 0x2002, WDATA = 0x1234 -> STRB = 1100, DMEM_WDATA = 0x12340000, WE = 1, STORE_DONE pulse after ACK.
- LW with ea = 0x1001 -> EXC_MISALIGN pulse, EXC_ADDR = 0x1001, DMEM_REQ never asserted, BUSY stays 0.
- XLEN = 64, LWU, ea = 0x4, RDATA = 0xF0000000_00000000 -> STRB = 0xF0, LOAD_DATA = 0x00000000_F0000000; LD on XLEN = 32 -> EXC_MISALIGN.
- ACK delayed 5 cycles with ISSUE pulsing during the wait -> REQ and signals stable for 5 cycles, extra ISSUEs ignored; NRST low in REQ -> DMEM_REQ = 0 immediately, no completion pulse.
- CORE_LSU_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ACK -> EXC_BUSERR pulse after 4 REQ cycles, then IDLE.

Source files
------------

// File: rtl/core_lsu_pkg.sv
// Shared encodings for the load/store control unit: FUNCT3 sizes, FSM states, size masks.
package core_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-lane mask for log2(access bytes); callers truncate to their strobe width.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational address/alignment stage: aligned address, byte strobes, lane-shifted
// store data and the illegal/misaligned flag.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SB_W = XLEN / 8,
  localparam int OFFW = $clog2(SB_W)
) (
  input  logic [XLEN-1:0] ea,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] addr,
  output logic [SB_W-1:0] strb,
  output logic [XLEN-1:0] wdata_sh,
  output logic            bad
);

  logic [OFFW-1:0] off;
  logic [1:0]      size;
  logic [7:0]      mask8;
  logic            illegal;
  logic            misalign;

  assign off      = ea[OFFW-1:0];
  assign size     = funct3[1:0];
  assign mask8    = size_mask(size);
  assign addr     = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign wdata_sh = wdata << {off, 3'b000};

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    if (funct3 == 3'b111) illegal = 1'b1;
    if (is_store && funct3[2]) illegal = 1'b1;
    if ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU))) illegal = 1'b1;
    case (size)
      2'd1:    misalign = ea[0];
      2'd2:    misalign = |ea[1:0];
      2'd3:    misalign = |ea[2:0];
      default: misalign = 1'b0;
    endcase
    bad  = illegal | misalign;
    strb = mask8[SB_W-1:0] << off;
  end

endmodule

// File: rtl/core_lsu_ctrl.sv
// Load/store control FSM with single-outstanding REQ/ACK and load extraction.
// Optional REQ watchdog and EXC_BUSERR port when CORE_LSU_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | accepting ISSUE; illegal/misaligned accesses fault here
// REQ     | DMEM_REQ high, request fields frozen until DMEM_ACK
// RESP    | one-cycle LOAD_VALID or STORE_DONE pulse
module core_lsu_ctrl
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SB_W = XLEN / 8
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            ISSUE,
  input  logic            ISLOAD,
  input  logic            ISSTORE,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] BASE,
  input  logic [XLEN-1:0] IMM,
  input  logic [XLEN-1:0] WDATA,
  output logic            BUSY,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [SB_W-1:0] DMEM_STRB,
  output logic [XLEN-1:0] DMEM_WDATA,
  input  logic            DMEM_ACK,
  input  logic [XLEN-1:0] DMEM_RDATA,
  output logic [XLEN-1:0] LOAD_DATA,
  output logic            LOAD_VALID,
  output logic            STORE_DONE,
  output logic            EXC_MISALIGN,
`ifdef CORE_LSU_TIMEOUT_EN
  output logic            EXC_BUSERR,
`endif
  output logic [XLEN-1:0] EXC_ADDR
);

  localparam int OFFW = $clog2(SB_W);

  logic [1:0]      state;
  logic [XLEN-1:0] ea;
  logic            is_st;
  logic            go;
  logic [XLEN-1:0] a_addr;
  logic [SB_W-1:0] a_strb;
  logic [XLEN-1:0] a_wdata;
  logic            a_bad;
  logic            we_q;
  logic [OFFW-1:0] off_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] ext;

`ifdef CORE_LSU_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [TW-1:0]   cnt;
  logic [XLEN-1:0] ea_q;
`endif

  assign ea    = BASE + IMM;
  assign is_st = ISSTORE & ~ISLOAD;
  assign go    = ISSUE & (ISLOAD | ISSTORE);

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .ea       (ea),
    .funct3   (FUNCT3),
    .is_store (is_st),
    .wdata    (WDATA),
    .addr     (a_addr),
    .strb     (a_strb),
    .wdata_sh (a_wdata),
    .bad      (a_bad)
  );

  // Load data is extracted straight off the bus on the ACK edge.
  assign rsh = DMEM_RDATA >> {off_q, 3'b000};

  always_comb begin
    ext = rsh;
    case (f3_q)
      F3_B:    ext = XLEN'($signed(rsh[7:0]));
      F3_H:    ext = XLEN'($signed(rsh[15:0]));
      F3_W:    ext = XLEN'($signed(rsh[31:0]));
      F3_BU:   ext = XLEN'(rsh[7:0]);
      F3_HU:   ext = XLEN'(rsh[15:0]);
      F3_WU:   ext = XLEN'(rsh[31:0]);
      default: ext = rsh;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state        <= ST_IDLE;
      DMEM_ADDR    <= '0;
      DMEM_STRB    <= '0;
      DMEM_WDATA   <= '0;
      we_q         <= 1'b0;
      off_q        <= '0;
      f3_q         <= '0;
      LOAD_DATA    <= '0;
      EXC_MISALIGN <= 1'b0;
      EXC_ADDR     <= '0;
`ifdef CORE_LSU_TIMEOUT_EN
      EXC_BUSERR   <= 1'b0;
      cnt          <= '0;
      ea_q         <= '0;
`endif
    end else begin
      EXC_MISALIGN <= 1'b0;
`ifdef CORE_LSU_TIMEOUT_EN
      EXC_BUSERR   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (go) begin
            if (a_bad) begin
              EXC_MISALIGN <= 1'b1;
              EXC_ADDR     <= ea;
            end else begin
              DMEM_ADDR  <= a_addr;
              DMEM_STRB  <= a_strb;
              DMEM_WDATA <= a_wdata;
              we_q       <= is_st;
              off_q      <= ea[OFFW-1:0];
              f3_q       <= FUNCT3;
`ifdef CORE_LSU_TIMEOUT_EN
              ea_q       <= ea;
              cnt        <= TW'(TIMEOUT_CYCLES - 1);
`endif
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (DMEM_ACK) begin
            if (!we_q) LOAD_DATA <= ext;
            state <= ST_RESP;
          end
`ifdef CORE_LSU_TIMEOUT_EN
          else if (cnt == '0) begin
            EXC_BUSERR <= 1'b1;
            EXC_ADDR   <= ea_q;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY       = (state != ST_IDLE);
  assign DMEM_REQ   = (state == ST_REQ);
  assign DMEM_WE    = we_q;
  assign LOAD_VALID = (state == ST_RESP) & ~we_q;
  assign STORE_DONE = (state == ST_RESP) & we_q;

endmodule
